// File: rtl/t_ff_counter.sv
// Parametrised up/down modulus counter built from per-bit toggle flip-flop logic.
// Optional sticky overflow flag (ovf/ovf_clr) enabled by defining T_FF_CNT_STICKY_OVF_EN.
module t_ff_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef T_FF_CNT_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             at_max;
    logic             at_zero;
    logic             at_end;
    logic             step;
    logic             wrap_evt;
    logic [WIDTH-1:0] load_eff;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t;

    assign at_max   = (q == MAX);
    assign at_zero  = (q == '0);
    assign at_end   = up_dn ? at_max : at_zero;
    assign step     = en & ~clr & ~load;
    assign wrap_evt = step & at_end & (SATURATE == 0);
    assign load_eff = (load_val > MAX) ? MAX : load_val;

    // Prefix-AND chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    // Range ends, clear and load are expressed as toggles t = q ^ next.
    always_comb begin
        t = '0;
        if (clr) begin
            t = q;
        end else if (load) begin
            t = q ^ load_eff;
        end else if (en) begin
            if (at_end) begin
                if (SATURATE == 0)
                    t = up_dn ? q : (q ^ MAX);
            end else begin
                t = up_dn ? up_t : dn_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q ^ t;
            wrap <= wrap_evt;
        end
    end

`ifdef T_FF_CNT_STICKY_OVF_EN
    // Set has priority over ovf_clr; clr and reset clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (clr)
            ovf <= 1'b0;
        else if (step & at_end)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

    assign qbar = ~q;
    assign tc   = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_t_ff_counter.sv
// Scoreboard bench for t_ff_counter: wrap, saturate and power-of-two instances share stimulus.
// Driver updates an arithmetic reference model and queues expectations; a monitor checks them.
module tb_t_ff_counter;

    logic       clk      = 1'b1;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b0;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr  = 1'b0;

    logic [3:0] q0, qb0, q1, qb1;
    logic [2:0] q2, qb2;
    logic       tc0, tc1, tc2, w0, w1, w2;
    logic       o0, o1, o2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int k;
        int q;
        bit tc;
        bit w;
        bit o;
    } exp_t;
    exp_t sb[$];

    int mq[3];
    bit mw[3];
    bit mo[3];

    always #5 clk = ~clk;

    t_ff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val),
`ifdef T_FF_CNT_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf(o0),
`endif
        .q(q0), .qbar(qb0), .tc(tc0), .wrap(w0));

    t_ff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val),
`ifdef T_FF_CNT_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf(o1),
`endif
        .q(q1), .qbar(qb1), .tc(tc1), .wrap(w1));

    t_ff_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_pow2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[2:0]),
`ifdef T_FF_CNT_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf(o2),
`endif
        .q(q2), .qbar(qb2), .tc(tc2), .wrap(w2));

`ifndef T_FF_CNT_STICKY_OVF_EN
    assign o0 = 1'b0;
    assign o1 = 1'b0;
    assign o2 = 1'b0;
`endif

    function automatic int modulus(input int k);
        return (k == 2) ? 8 : 10;
    endfunction

    function automatic bit saturates(input int k);
        return (k == 1);
    endfunction

    // Reference model: one rising edge using the controls currently applied.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int mx;
            int lv;
            bit at_end;
            mx     = modulus(k) - 1;
            lv     = (k == 2) ? int'(load_val) % 8 : int'(load_val);
            at_end = up_dn ? (mq[k] == mx) : (mq[k] == 0);
            mw[k]  = 1'b0;
            if (!rst_n) begin
                mq[k] = 0;
                mo[k] = 1'b0;
            end else if (clr) begin
                mq[k] = 0;
                mo[k] = 1'b0;
            end else if (load) begin
                mq[k] = (lv > mx) ? mx : lv;
                if (ovf_clr) mo[k] = 1'b0;
            end else if (en) begin
                if (at_end) begin
                    mo[k] = 1'b1;
                    if (!saturates(k)) begin
                        mq[k] = up_dn ? 0 : mx;
                        mw[k] = 1'b1;
                    end
                end else begin
                    mq[k] = up_dn ? mq[k] + 1 : mq[k] - 1;
                    if (ovf_clr) mo[k] = 1'b0;
                end
            end else if (ovf_clr) begin
                mo[k] = 1'b0;
            end
        end
    endtask

    task automatic push_expect();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            int mx;
            mx   = modulus(k) - 1;
            e.k  = k;
            e.q  = mq[k];
            e.tc = en & ((up_dn & (mq[k] == mx)) | (!up_dn & (mq[k] == 0)));
            e.w  = mw[k];
            e.o  = mo[k];
            sb.push_back(e);
        end
    endtask

    // Shortly after each rising edge: advance the model, apply new controls, queue expectations.
    task automatic drive(input bit r, input bit c, input bit l, input logic [3:0] lv,
                         input bit e, input bit u, input bit oc);
        @(posedge clk);
        #2;
        model_edge();
        rst_n    = r;
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = u;
        ovf_clr  = oc;
        if (!r) begin
            for (int k = 0; k < 3; k++) begin
                mq[k] = 0;
                mw[k] = 1'b0;
                mo[k] = 1'b0;
            end
        end
        push_expect();
    endtask

    task automatic check(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            int gq, gqb, gtc, gw, go, mask;
            e = sb.pop_front();
            case (e.k)
                0:       begin gq = int'(q0); gqb = int'(qb0); gtc = int'(tc0); gw = int'(w0); go = int'(o0); mask = 15; end
                1:       begin gq = int'(q1); gqb = int'(qb1); gtc = int'(tc1); gw = int'(w1); go = int'(o1); mask = 15; end
                default: begin gq = int'(q2); gqb = int'(qb2); gtc = int'(tc2); gw = int'(w2); go = int'(o2); mask = 7;  end
            endcase
            check("q", e.k, gq, e.q);
            check("qbar", e.k, gqb, (~e.q) & mask);
            check("tc", e.k, gtc, int'(e.tc));
            check("wrap", e.k, gw, int'(e.w));
`ifdef T_FF_CNT_STICKY_OVF_EN
            check("ovf", e.k, go, int'(e.o));
`endif
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0;
            mw[k] = 1'b0;
            mo[k] = 1'b0;
        end
        push_expect();

        // reset, then count up 12 edges
        drive(0, 0, 0, 4'd0, 0, 1, 0);
        drive(1, 0, 0, 4'd0, 1, 1, 0);
        repeat (12) drive(1, 0, 0, 4'd0, 1, 1, 0);

        // down from 0
        drive(1, 1, 0, 4'd0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 4'd0, 1, 0, 0);

        // load 9 then up (saturate holds), then down from 0
        drive(1, 0, 1, 4'd9, 0, 1, 0);
        repeat (3) drive(1, 0, 0, 4'd0, 1, 1, 0);
        drive(1, 1, 0, 4'd0, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 4'd0, 1, 0, 0);

        // clamp, clr beats load, en=0 hold
        drive(1, 0, 1, 4'd13, 0, 1, 0);
        drive(1, 1, 1, 4'd5, 0, 1, 0);
        drive(1, 0, 1, 4'd7, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 4'd0, 0, 1, 0);

        // reset mid-cycle at q=6, then resume
        drive(1, 1, 0, 4'd0, 0, 1, 0);
        repeat (6) drive(1, 0, 0, 4'd0, 1, 1, 0);
        drive(0, 0, 0, 4'd0, 1, 1, 0);
        drive(1, 0, 0, 4'd0, 1, 1, 0);
        repeat (3) drive(1, 0, 0, 4'd0, 1, 1, 0);

        // sticky overflow: set, persist, clear, clear coinciding with wrap
        drive(1, 0, 1, 4'd9, 0, 1, 0);
        drive(1, 0, 0, 4'd0, 1, 1, 0);
        repeat (3) drive(1, 0, 0, 4'd0, 0, 1, 0);
        drive(1, 0, 0, 4'd0, 0, 1, 1);
        drive(1, 0, 1, 4'd9, 0, 1, 0);
        drive(1, 0, 0, 4'd0, 1, 1, 1);
        repeat (2) drive(1, 0, 0, 4'd0, 0, 1, 0);

        repeat (400) begin
            bit r, c, l, e, u, oc;
            r  = ($urandom_range(99) >= 2);
            c  = ($urandom_range(99) < 5);
            l  = ($urandom_range(99) < 10);
            e  = ($urandom_range(99) < 75);
            u  = ($urandom_range(99) < 55);
            oc = ($urandom_range(99) < 10);
            drive(r, c, l, 4'($urandom_range(15)), e, u, oc);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
